dcache_dm: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between processor and data memory.
//  CPU side: byte read/write with busy_wait stall, the same contract the register file and PC already honour.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_line_store.sv | 52 +++++
 rtl/dcache_dm.sv | 107 ++++++++++
 tb/tb_dcache_dm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encoding and address field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int IDX_W       = $clog2(NUM_BLOCKS);
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W      = DATA_W * BLOCK_BYTES;
    localparam int BLK_ADDR_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    // Byte 0 of a line lives in bits [DATA_W-1:0].
    typedef logic [BLOCK_BYTES-1:0][DATA_W-1:0] line_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Cache line storage: combinational read of one line, byte store or whole-line fill at posedge.
// Only valid/dirty are reset; tag and data contents survive reset and are ignored while invalid.
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic             dirty_o,
    output logic [TAG_W-1:0] tag_o,
    output line_t            line_o,
    input  logic             byte_we_i,
    input  logic [OFF_W-1:0] byte_off_i,
    input  logic [DATA_W-1:0] byte_dat_i,
    input  logic             fill_we_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  line_t            fill_line_i
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    line_t                 data_q [NUM_BLOCKS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (byte_we_i) begin
            data_q[idx_i][byte_off_i] <= byte_dat_i;
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back/write-allocate data cache: hits are zero-latency, misses stall the CPU
// via busy_wait for an optional dirty writeback plus an allocate, each gated by mem_busywait.
module dcache_dm
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     read_data,
    output logic                  busy_wait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BLK_ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0]     mem_writedata,
    input  logic [LINE_W-1:0]     mem_readdata,
    input  logic                  mem_busywait
);

    state_e state_q, state_d;

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off;
    logic             req;
    logic             hit;
    logic             serve;
    logic             line_valid;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    line_t            line_rd;
    logic             fill_we;

    assign a_tag = addr_tag(address);
    assign a_idx = addr_idx(address);
    assign a_off = addr_off(address);

    // Simultaneous read and write is not a request; reset silences the CPU side immediately.
    assign req   = (read ^ write) && !rst;
    assign hit   = line_valid && (line_tag == a_tag);
    assign serve = req && (state_q == IDLE) && hit;

    assign busy_wait = req && !((state_q == IDLE) && hit);
    assign read_data = (serve && read) ? line_rd[a_off] : '0;

    dcache_line_store u_store (
        .clk         (clk),
        .rst         (rst),
        .idx_i       (a_idx),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .line_o      (line_rd),
        .byte_we_i   (serve && write),
        .byte_off_i  (a_off),
        .byte_dat_i  (write_data),
        .fill_we_i   (fill_we),
        .fill_tag_i  (a_tag),
        .fill_line_i (line_t'(mem_readdata))
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        fill_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {line_tag, a_idx};
                mem_writedata = line_rd;
                if (!mem_busywait) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = {a_tag, a_idx};
                if (!mem_busywait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: 20-cycle block memory plus an architectural byte-memory reference model.
module tb_dcache_dm;

    localparam int MEM_LAT = 20;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        busy_wait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_chk = 0;
    int n_err = 0;

    dcache_dm dut (
        .clk           (clk),
        .rst           (rst),
        .read          (read),
        .write         (write),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data),
        .busy_wait     (busy_wait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block memory: a request is held for MEM_LAT cycles, busywait low in the last one.
    logic [31:0] bmem [64];
    int          mcnt = 0;
    bit          mem_init_done = 1'b0;

    assign mem_busywait = (mem_read || mem_write) && (mcnt < MEM_LAT - 1);
    assign mem_readdata = bmem[mem_address];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) bmem[i] <= $urandom;
            mem_init_done <= 1'b1;
        end else if (mem_read || mem_write) begin
            if (mcnt == MEM_LAT - 1) begin
                mcnt <= 0;
                if (mem_write) bmem[mem_address] <= mem_writedata;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // Reference: architectural byte view plus which block each line holds.
    logic [7:0] arch [256];
    bit         mv [8];
    bit         md [8];
    logic [2:0] mt [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // After reset the cache holds nothing, so memory is the whole truth.
    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        for (int a = 0; a < 256; a++) arch[a] = bmem[a >> 2][(a & 3) * 8 +: 8];
    endtask

    task automatic access(input bit is_wr, input logic [7:0] a, input logic [7:0] d);
        int          idx;
        logic [2:0]  t;
        bit          exp_hit;
        bit          exp_wb;
        int          exp_stall;
        int          stall;
        bit          saw_wr;
        bit          saw_rd;
        bit          both;
        logic [5:0]  wb_addr;
        logic [5:0]  al_addr;
        logic [31:0] wb_dat;
        logic [31:0] exp_line;
        logic [7:0]  base;
        idx       = int'(a[4:2]);
        t         = a[7:5];
        exp_hit   = mv[idx] && (mt[idx] == t);
        exp_wb    = !exp_hit && mv[idx] && md[idx];
        exp_stall = exp_hit ? 0 : (exp_wb ? 1 + 2 * MEM_LAT : 1 + MEM_LAT);
        stall = 0; saw_wr = 0; saw_rd = 0; both = 0;
        wb_addr = '0; al_addr = '0; wb_dat = '0;
        @(negedge clk);
        read = !is_wr; write = is_wr; address = a; write_data = d;
        #1;
        while (busy_wait && stall < 200) begin
            if (mem_read && mem_write) both = 1;
            if (mem_write && !saw_wr) begin
                saw_wr = 1; wb_addr = mem_address; wb_dat = mem_writedata;
            end
            if (mem_read && !saw_rd) begin
                saw_rd = 1; al_addr = mem_address;
            end
            stall++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", stall, exp_stall);
        chk("mem_rd_wr_exclusive", both, 0);
        chk("writeback_seen", saw_wr, exp_wb);
        chk("allocate_seen", saw_rd, !exp_hit);
        if (exp_wb) begin
            base = {mt[idx], a[4:2], 2'b00};
            for (int b = 0; b < 4; b++) exp_line[b * 8 +: 8] = arch[base + 8'(b)];
            chk("wb_addr", wb_addr, {mt[idx], a[4:2]});
            chk("wb_data", wb_dat, exp_line);
        end
        if (!exp_hit) chk("alloc_addr", al_addr, a[7:2]);
        if (is_wr) begin
            arch[a] = d;
        end else begin
            chk("read_data", read_data, arch[a]);
        end
        md[idx] = exp_hit ? (md[idx] | is_wr) : is_wr;
        mv[idx] = 1'b1;
        mt[idx] = t;
    endtask

    task automatic go_idle();
        @(negedge clk);
        read = 0; write = 0;
    endtask

    initial begin
        int n;
        rst = 1; read = 0; write = 0; address = '0; write_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy_wait", busy_wait, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_writedata", mem_writedata, 0);
        chk("rst_read_data", read_data, 0);
        @(negedge clk);
        rst = 0;
        model_reset();

        access(0, 8'h19, 8'h00);              // cold miss, allocate only
        access(0, 8'h1A, 8'h00);              // hit in same line
        access(1, 8'h19, 8'd45);              // write hit, line becomes dirty
        access(0, 8'h19, 8'h00);
        chk("read_back_45", read_data, 8'd45);
        access(0, 8'h39, 8'h00);              // conflict: writeback block 0x06 then allocate 0x0E
        go_idle();
        chk("mem_blk6_byte1", bmem[6][15:8], 8'd45);

        // Reset five cycles into an allocate.
        @(negedge clk);
        read = 1; write = 0; address = 8'h59;
        #1;
        n = 0;
        while (!mem_read && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("abort_alloc_started", mem_read, 1);
        repeat (5) @(negedge clk);
        rst = 1;
        #1;
        chk("abort_mem_read", mem_read, 0);
        chk("abort_busy_wait", busy_wait, 0);
        chk("abort_mem_write", mem_write, 0);
        @(negedge clk);
        rst = 0; read = 0;
        model_reset();
        access(0, 8'h39, 8'h00);              // must miss again

        access(1, 8'h10, 8'd65);              // write miss on clean line
        access(0, 8'h10, 8'h00);
        chk("read_back_65", read_data, 8'd65);

        // Read and write together is not a request.
        @(negedge clk);
        read = 1; write = 1; address = 8'h10; write_data = 8'h99;
        #1;
        chk("illegal_busy_wait", busy_wait, 0);
        chk("illegal_mem_read", mem_read, 0);
        chk("illegal_read_data", read_data, 0);
        go_idle();
        access(0, 8'h10, 8'h00);

        for (int i = 0; i < 250; i++) begin
            logic [7:0] a;
            a = {3'($urandom_range(0, 3)), 5'($urandom)};
            access(1'($urandom), a, 8'($urandom));
            if ($urandom_range(0, 7) == 0) go_idle();
        end
        go_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
